// File: rtl/read_submodule.sv
// read_submodule: single-beat AR/R read initiator returning data and resp with a one-cycle done pulse
module read_submodule #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_address,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic              r_resp,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              resp,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;
  state_t state, state_nx;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? ADDR : IDLE;
      ADDR: state_nx = ar_ready ? DATA : ADDR;
      DATA: state_nx = r_valid ? DONE : DATA;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // handshake outputs are pure state decodes, so no input reaches an output combinationally
  assign ar_valid = state == ADDR;
  assign r_ready  = state == DATA;
  assign done     = state == DONE;
  assign busy     = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ar_address <= '0;
      data       <= '0;
      resp       <= 1'b0;
    end else begin
      if (state == IDLE && start) ar_address <= addr;
      if (state == DATA && r_valid) begin
        data <= r_data;
        resp <= r_resp;
      end
    end
endmodule

// File: doc/read_submodule.md
Name: read_submodule

Overview:
Single-beat read initiator. It is the read-direction companion to the write submodule and uses the same memory channel style: valid/ready handshakes, a 4-bit word address, 32-bit data and a 1-bit response. The supermodule issues `start` with an address. The block drives the AR channel, accepts one R beat, and returns the data and response with a one-cycle `done` pulse. It sits between the sorting supermodule and the memory, alongside the write submodule.

Parameters:
ADDR_W, 4, address width; matches the write-side aw_address.
DATA_W, 32, data width; matches the write-side w_data.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  asynchronous active-low reset
ar_valid  output  1  read-address valid
ar_ready  input  1  read-address ready from memory
ar_address  output  ADDR_W  read address
r_valid  input  1  read-data valid from memory
r_ready  output  1  read-data ready
r_data  input  DATA_W  read data
r_resp  input  1  read response: 0 = OK, 1 = error
start  input  1  supermodule request; sampled only in IDLE
addr  input  ADDR_W  address to read; sampled with start
data  output  DATA_W  captured read data
done  output  1  one-cycle completion pulse
resp  output  1  captured r_resp
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - ar_valid = 0, r_ready = 0, done = 0, busy = 0.
  - ar_address = 0, data = 0, resp = 0.
  - Reset mid-transaction abandons the transaction; no done is produced.
- FSM states: IDLE, ADDR, DATA, DONE. All outputs are registered or decoded from state only; no combinational path from input to output.
- IDLE:
  - When start = 1, latch addr into ar_address and go to ADDR.
  - start in any other state is ignored and not queued.
- ADDR:
  - ar_valid = 1, and it does not depend on ar_ready.
  - ar_address is held stable until the handshake.
  - When ar_valid and ar_ready are both high at a clock edge, go to DATA; ar_valid is 0 from the next cycle.
  - r_valid is ignored in ADDR (r_ready = 0).
- DATA:
  - r_ready = 1.
  - On r_valid and r_ready both high, capture r_data into data and r_resp into resp, then go to DONE.
  - Waiting for r_valid is unbounded; there is no timeout.
- DONE:
  - done = 1 for exactly one cycle, then go to IDLE.
  - busy is 1 in ADDR, DATA and DONE.
- Outputs data and resp:
  - Hold their values from the DONE cycle until the next R capture, including through IDLE.
  - data is captured regardless of resp; on resp = 1, data is whatever memory returned.
- Latency:
  - start is sampled at edge 0; ar_valid is high in cycle 1.
  - With ar_ready and r_valid both already high, done is high in cycle 3. Minimum start-to-done is 3 cycles.
  - Back-to-back: the next start is accepted in the cycle after DONE, so the minimum period is 4 cycles.
- ar_address retains its last value after the handshake; it is only reloaded on an accepted start.

Test Plan:
1. Zero-wait read: memory holds ar_ready = 1 and r_valid = 1 with r_data = 0xDEADBEEF, r_resp = 0; pulse start with addr = 0x5 -> ar_valid high in cycle 1 with ar_address = 0x5; r_ready high in cycle 2; done high only in cycle 3 with data = 0xDEADBEEF, resp = 0.
2. AR backpressure: ar_ready held low for 5 cycles, addr = 0xA -> ar_valid and ar_address = 0xA stay stable for all 5 cycles; r_ready stays 0 until after the handshake; exactly one done pulse follows.
3. Delayed R with error: r_valid arrives 4 cycles after the AR handshake with r_data = 0x12345678, r_resp = 1 -> r_ready is high throughout the wait; done is pulsed once with resp = 1 and data = 0x12345678.
4. Ignored start: pulse start with addr = 0x3 while in DATA -> no second AR transaction; ar_address stays at the original address; exactly one done pulse.
5. Early r_valid: r_valid = 1 during ADDR with ar_ready = 0 -> r_ready = 0 and no capture; data is captured only after the AR handshake.
6. Reset mid-operation: assert rst_n = 0 while in DATA -> in the same cycle, all outputs go to 0 and busy = 0; no done pulse; a new start after release completes normally.
